rf_write_arbiter: RTL and testbench

RF_WRITE_ARBITER -- requirements
Module: rf_write_arbiter

---
 rtl/rf_arb_pkg.sv | 18 +
 rtl/rf_scoreboard.sv | 56 +++++
 rtl/rf_write_arbiter.sv | 142 ++++++++++++++
 tb/tb_rf_write_arbiter.sv | 234 +++++++++++++++++++++++
 4 files changed

// File: rtl/rf_arb_pkg.sv
// Shared definitions for the register-file write arbiter.
// The register address and data widths, the default starvation limit, and
// the requester encoding. The encoding is also driven out on grant_src.
package rf_arb_pkg;

  localparam int REG_ADDR_W           = 5;
  localparam int DATA_W               = 32;
  localparam int NUM_REGS             = 1 << REG_ADDR_W;
  localparam int STARVE_LIMIT_DEFAULT = 8;

  typedef enum logic [1:0] {
    SRC_NONE = 2'd0,
    SRC_WB   = 2'd1,
    SRC_MDU  = 2'd2,
    SRC_LSU  = 2'd3
  } req_src_e;

endpackage

// File: rtl/rf_scoreboard.sv
// Busy-register scoreboard.
// The scoreboard sets a bit when a long-latency op reserves its destination.
// It clears that bit when the MDU or LSU writes the register back.
// When a set and a clear hit the same bit in one cycle, the set wins.
// Register 0 is never busy.
// Ports:
//   clk_n, rst_n          clock (rising edge) and async active-low reset
//   set_valid, set_addr   reservation request
//   clr_valid, clr_addr   long-latency writeback retiring a reservation
//   q_addr1/2, q_busy1/2  combinational busy lookup
module rf_scoreboard
  import rf_arb_pkg::*;
(
  input  logic                  clk_n,
  input  logic                  rst_n,
  input  logic                  set_valid,
  input  logic [REG_ADDR_W-1:0] set_addr,
  input  logic                  clr_valid,
  input  logic [REG_ADDR_W-1:0] clr_addr,
  input  logic [REG_ADDR_W-1:0] q_addr1,
  input  logic [REG_ADDR_W-1:0] q_addr2,
  output logic                  q_busy1,
  output logic                  q_busy2
);

  logic [NUM_REGS-1:0] busy_reg;
  logic [NUM_REGS-1:0] busy_next;

  // Register 0 is hardwired to zero, so it can never be outstanding.
  assign busy_next[0] = 1'b0;

  genvar gi;
  generate
    for (gi = 1; gi < NUM_REGS; gi++) begin : g_bit
      logic set_hit;
      logic clr_hit;
      assign set_hit = set_valid && (set_addr == REG_ADDR_W'(gi));
      assign clr_hit = clr_valid && (clr_addr == REG_ADDR_W'(gi));
      // A new reservation issued in the same cycle as the old one retires
      // must survive.
      assign busy_next[gi] = set_hit | (busy_reg[gi] & ~clr_hit);
    end
  endgenerate

  always_ff @(posedge clk_n or negedge rst_n) begin
    if (!rst_n) begin
      busy_reg <= '0;
    end else begin
      busy_reg <= busy_next;
    end
  end

  assign q_busy1 = (q_addr1 != '0) && busy_reg[q_addr1];
  assign q_busy2 = (q_addr2 != '0) && busy_reg[q_addr2];

endmodule

// File: rtl/rf_write_arbiter.sv
// Register-file write-port arbiter.
// Three writers share the register-file write port: pipeline writeback (WB),
// the multiply/divide unit (MDU) and the load/store unit (LSU).
// WB normally wins. Once a long-latency requester has lost to WB for
// STARVE_LIMIT consecutive cycles, WB is held off for one cycle.
// MDU and LSU share the remaining slots round-robin.
// The granted write is driven out on the following cycle.
// Writes to register 0 complete their handshake but are not written.
// Ports:
//   clk_n, rst_n                        clock (rising edge), async active-low reset
//   wb_*/mdu_*/lsu_* valid/addr/data    write requests; *_ready is the grant
//   rsv_valid, rsv_addr                 destination reservation from issue
//   q_addr1/2, q_busy1/2                scoreboard busy lookup
//   write_enable/addr/data              registered register-file write port
//   grant_src                           registered source of the current write
module rf_write_arbiter
  import rf_arb_pkg::*;
#(
  parameter int STARVE_LIMIT = STARVE_LIMIT_DEFAULT
) (
  input  logic                  clk_n,
  input  logic                  rst_n,
  input  logic                  wb_valid,
  input  logic [REG_ADDR_W-1:0] wb_addr,
  input  logic [DATA_W-1:0]     wb_data,
  output logic                  wb_ready,
  input  logic                  mdu_valid,
  input  logic [REG_ADDR_W-1:0] mdu_addr,
  input  logic [DATA_W-1:0]     mdu_data,
  output logic                  mdu_ready,
  input  logic                  lsu_valid,
  input  logic [REG_ADDR_W-1:0] lsu_addr,
  input  logic [DATA_W-1:0]     lsu_data,
  output logic                  lsu_ready,
  input  logic                  rsv_valid,
  input  logic [REG_ADDR_W-1:0] rsv_addr,
  input  logic [REG_ADDR_W-1:0] q_addr1,
  input  logic [REG_ADDR_W-1:0] q_addr2,
  output logic                  q_busy1,
  output logic                  q_busy2,
  output logic                  write_enable,
  output logic [REG_ADDR_W-1:0] write_addr,
  output logic [DATA_W-1:0]     write_data,
  output logic [1:0]            grant_src
);

  localparam logic [3:0] STARVE_MAX = 4'(STARVE_LIMIT);

  logic [3:0]            starve_cnt_reg;
  logic [3:0]            starve_cnt_next;
  logic                  mdu_first_reg;   // 1: MDU wins an MDU/LSU tie
  logic                  wb_gnt;
  logic                  mdu_gnt;
  logic                  lsu_gnt;
  logic                  long_valid;
  req_src_e              sel_src;
  logic [REG_ADDR_W-1:0] sel_addr;
  logic [DATA_W-1:0]     sel_data;

  // Grants are combinational from the valids and the registered state. They
  // are gated by rst_n so that nothing handshakes while reset is held.
  assign long_valid = mdu_valid || lsu_valid;
  assign wb_ready   = rst_n && (starve_cnt_reg != STARVE_MAX);
  assign wb_gnt     = wb_valid && wb_ready;
  assign mdu_gnt    = rst_n && !wb_gnt && mdu_valid && (!lsu_valid || mdu_first_reg);
  assign lsu_gnt    = rst_n && !wb_gnt && lsu_valid && (!mdu_valid || !mdu_first_reg);
  assign mdu_ready  = mdu_gnt;
  assign lsu_ready  = lsu_gnt;

  always_comb begin
    sel_src  = SRC_NONE;
    sel_addr = '0;
    sel_data = '0;
    if (wb_gnt) begin
      sel_src  = SRC_WB;
      sel_addr = wb_addr;
      sel_data = wb_data;
    end else if (mdu_gnt) begin
      sel_src  = SRC_MDU;
      sel_addr = mdu_addr;
      sel_data = mdu_data;
    end else if (lsu_gnt) begin
      sel_src  = SRC_LSU;
      sel_addr = lsu_addr;
      sel_data = lsu_data;
    end
  end

  // The count is the number of consecutive WB wins while a long-latency
  // requester waits. Any long-latency grant clears it. So does a cycle in
  // which no long-latency requester is waiting.
  always_comb begin
    starve_cnt_next = starve_cnt_reg;
    if (mdu_gnt || lsu_gnt || !long_valid) begin
      starve_cnt_next = '0;
    end else if (wb_gnt && (starve_cnt_reg != STARVE_MAX)) begin
      starve_cnt_next = starve_cnt_reg + 4'd1;
    end
  end

  always_ff @(posedge clk_n or negedge rst_n) begin
    if (!rst_n) begin
      starve_cnt_reg <= '0;
      mdu_first_reg  <= 1'b1;
      write_enable   <= 1'b0;
      write_addr     <= '0;
      write_data     <= '0;
      grant_src      <= SRC_NONE;
    end else begin
      starve_cnt_reg <= starve_cnt_next;
      if (mdu_gnt) begin
        mdu_first_reg <= 1'b0;
      end else if (lsu_gnt) begin
        mdu_first_reg <= 1'b1;
      end
      grant_src <= sel_src;
      if (sel_src != SRC_NONE) begin
        write_addr   <= sel_addr;
        write_data   <= sel_data;
        write_enable <= (sel_addr != '0);
      end else begin
        // Idle cycles hold the last address and data so the port stays quiet.
        write_enable <= 1'b0;
      end
    end
  end

  // Only long-latency results retire reservations. WB writes never clear them.
  rf_scoreboard u_scoreboard (
    .clk_n     (clk_n),
    .rst_n     (rst_n),
    .set_valid (rsv_valid),
    .set_addr  (rsv_addr),
    .clr_valid (mdu_gnt || lsu_gnt),
    .clr_addr  (mdu_gnt ? mdu_addr : lsu_addr),
    .q_addr1   (q_addr1),
    .q_addr2   (q_addr2),
    .q_busy1   (q_busy1),
    .q_busy2   (q_busy2)
  );

endmodule

// File: tb/tb_rf_write_arbiter.sv
module tb_rf_write_arbiter;
  import rf_arb_pkg::*;

  logic                  clk_n;
  logic                  rst_n;
  logic                  wb_valid;
  logic [REG_ADDR_W-1:0] wb_addr;
  logic [DATA_W-1:0]     wb_data;
  logic                  wb_ready;
  logic                  mdu_valid;
  logic [REG_ADDR_W-1:0] mdu_addr;
  logic [DATA_W-1:0]     mdu_data;
  logic                  mdu_ready;
  logic                  lsu_valid;
  logic [REG_ADDR_W-1:0] lsu_addr;
  logic [DATA_W-1:0]     lsu_data;
  logic                  lsu_ready;
  logic                  rsv_valid;
  logic [REG_ADDR_W-1:0] rsv_addr;
  logic [REG_ADDR_W-1:0] q_addr1;
  logic [REG_ADDR_W-1:0] q_addr2;
  logic                  q_busy1;
  logic                  q_busy2;
  logic                  write_enable;
  logic [REG_ADDR_W-1:0] write_addr;
  logic [DATA_W-1:0]     write_data;
  logic [1:0]            grant_src;

  int n_checks = 0;
  int n_errors = 0;

  rf_write_arbiter #(.STARVE_LIMIT(8)) dut (
    .clk_n        (clk_n),
    .rst_n        (rst_n),
    .wb_valid     (wb_valid),
    .wb_addr      (wb_addr),
    .wb_data      (wb_data),
    .wb_ready     (wb_ready),
    .mdu_valid    (mdu_valid),
    .mdu_addr     (mdu_addr),
    .mdu_data     (mdu_data),
    .mdu_ready    (mdu_ready),
    .lsu_valid    (lsu_valid),
    .lsu_addr     (lsu_addr),
    .lsu_data     (lsu_data),
    .lsu_ready    (lsu_ready),
    .rsv_valid    (rsv_valid),
    .rsv_addr     (rsv_addr),
    .q_addr1      (q_addr1),
    .q_addr2      (q_addr2),
    .q_busy1      (q_busy1),
    .q_busy2      (q_busy2),
    .write_enable (write_enable),
    .write_addr   (write_addr),
    .write_data   (write_data),
    .grant_src    (grant_src)
  );

  initial begin
    clk_n = 1'b0;
    forever #5 clk_n = ~clk_n;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end else begin
      $display("ok   %s = 0x%0h", tag, obs);
    end
  endtask

  // Advance one rising edge and settle just after it.
  task automatic tick();
    @(posedge clk_n);
    #1;
  endtask

  task automatic idle_inputs();
    wb_valid  = 1'b0; wb_addr  = '0; wb_data  = '0;
    mdu_valid = 1'b0; mdu_addr = '0; mdu_data = '0;
    lsu_valid = 1'b0; lsu_addr = '0; lsu_data = '0;
    rsv_valid = 1'b0; rsv_addr = '0;
  endtask

  initial begin
    idle_inputs();
    q_addr1 = '0;
    q_addr2 = '0;
    rst_n   = 1'b0;

    // Reset: outputs clear, and no ready is given even with a valid present.
    wb_valid = 1'b1;
    #1;
    check("rst_wb_ready", 32'(wb_ready), 32'd0);
    tick();
    check("rst_write_enable", 32'(write_enable), 32'd0);
    check("rst_grant_src", 32'(grant_src), 32'd0);
    check("rst_write_data", write_data, 32'd0);
    wb_valid = 1'b0;
    tick();
    rst_n = 1'b1;

    // A single WB write.
    wb_valid = 1'b1; wb_addr = 5'd5; wb_data = 32'hA5A5_A5A5;
    #1;
    check("wb_ready", 32'(wb_ready), 32'd1);
    tick();
    wb_valid = 1'b0;
    check("wb_we", 32'(write_enable), 32'd1);
    check("wb_waddr", 32'(write_addr), 32'd5);
    check("wb_wdata", write_data, 32'hA5A5_A5A5);
    check("wb_src", 32'(grant_src), 32'(SRC_WB));
    tick();
    check("idle_we", 32'(write_enable), 32'd0);
    check("idle_src", 32'(grant_src), 32'(SRC_NONE));
    check("idle_hold_addr", 32'(write_addr), 32'd5);
    check("idle_hold_data", write_data, 32'hA5A5_A5A5);

    // MDU and LSU both held: MDU goes first out of reset, then they alternate.
    mdu_valid = 1'b1; mdu_addr = 5'd3; mdu_data = 32'h0000_0030;
    lsu_valid = 1'b1; lsu_addr = 5'd4; lsu_data = 32'h0000_0040;
    for (int i = 0; i < 4; i++) begin
      #1;
      check($sformatf("rr%0d_mdu_ready", i), 32'(mdu_ready), (i % 2 == 0) ? 32'd1 : 32'd0);
      check($sformatf("rr%0d_lsu_ready", i), 32'(lsu_ready), (i % 2 == 0) ? 32'd0 : 32'd1);
      tick();
      check($sformatf("rr%0d_src", i), 32'(grant_src),
            (i % 2 == 0) ? 32'(SRC_MDU) : 32'(SRC_LSU));
      check($sformatf("rr%0d_waddr", i), 32'(write_addr), (i % 2 == 0) ? 32'd3 : 32'd4);
    end
    lsu_valid = 1'b0;

    // WB held with MDU waiting: WB wins 8 cycles, then MDU gets cycle 9.
    wb_valid = 1'b1; wb_addr = 5'd10;
    mdu_addr = 5'd11; mdu_data = 32'h0000_0011;
    for (int c = 1; c <= 10; c++) begin
      wb_data = 32'(c);
      #1;
      check($sformatf("starve_c%0d_wb_ready", c), 32'(wb_ready), (c == 9) ? 32'd0 : 32'd1);
      check($sformatf("starve_c%0d_mdu_ready", c), 32'(mdu_ready), (c == 9) ? 32'd1 : 32'd0);
      tick();
      check($sformatf("starve_c%0d_src", c), 32'(grant_src),
            (c == 9) ? 32'(SRC_MDU) : 32'(SRC_WB));
    end
    idle_inputs();
    tick();

    // Reserve r7. It stays busy until the MDU writes it back.
    q_addr1 = 5'd7;
    rsv_valid = 1'b1; rsv_addr = 5'd7;
    #1;
    check("rsv7_before", 32'(q_busy1), 32'd0);
    tick();
    rsv_valid = 1'b0;
    check("rsv7_set", 32'(q_busy1), 32'd1);
    tick();
    check("rsv7_held", 32'(q_busy1), 32'd1);
    mdu_valid = 1'b1; mdu_addr = 5'd7; mdu_data = 32'h0000_0077;
    #1;
    check("rsv7_mdu_ready", 32'(mdu_ready), 32'd1);
    check("rsv7_busy_at_grant", 32'(q_busy1), 32'd1);
    tick();
    mdu_valid = 1'b0;
    check("rsv7_cleared", 32'(q_busy1), 32'd0);
    check("rsv7_waddr", 32'(write_addr), 32'd7);
    check("rsv7_src", 32'(grant_src), 32'(SRC_MDU));

    // Re-reserve r9 in the same cycle as an LSU write to r9: the set wins.
    q_addr2 = 5'd9;
    rsv_valid = 1'b1; rsv_addr = 5'd9;
    lsu_valid = 1'b1; lsu_addr = 5'd9; lsu_data = 32'h0000_0099;
    #1;
    check("r9_lsu_ready", 32'(lsu_ready), 32'd1);
    tick();
    rsv_valid = 1'b0; lsu_valid = 1'b0;
    check("r9_busy_kept", 32'(q_busy2), 32'd1);
    check("r9_src", 32'(grant_src), 32'(SRC_LSU));

    // An LSU write to r0 completes its handshake but does not write.
    // Reserving r0 is ignored.
    lsu_valid = 1'b1; lsu_addr = 5'd0; lsu_data = 32'h0000_DEAD;
    rsv_valid = 1'b1; rsv_addr = 5'd0;
    q_addr1 = 5'd0;
    #1;
    check("r0_lsu_ready", 32'(lsu_ready), 32'd1);
    tick();
    lsu_valid = 1'b0; rsv_valid = 1'b0;
    check("r0_we", 32'(write_enable), 32'd0);
    check("r0_src", 32'(grant_src), 32'(SRC_LSU));
    check("r0_wdata", write_data, 32'h0000_DEAD);
    check("r0_busy", 32'(q_busy1), 32'd0);

    // A WB write to r9 leaves its reservation alone.
    wb_valid = 1'b1; wb_addr = 5'd9; wb_data = 32'h0000_0909;
    tick();
    wb_valid = 1'b0;
    check("wb_r9_we", 32'(write_enable), 32'd1);
    check("wb_r9_busy_kept", 32'(q_busy2), 32'd1);

    // An MDU grant points round-robin at the LSU. Reset mid-grant must
    // restore MDU-first.
    mdu_valid = 1'b1; mdu_addr = 5'd12; mdu_data = 32'h0000_000C;
    tick();
    check("pre_rst_src", 32'(grant_src), 32'(SRC_MDU));
    mdu_addr = 5'd13; mdu_data = 32'h0000_000D;
    #1;
    rst_n = 1'b0;
    #1;
    check("mid_rst_mdu_ready", 32'(mdu_ready), 32'd0);
    check("mid_rst_we", 32'(write_enable), 32'd0);
    check("mid_rst_waddr", 32'(write_addr), 32'd0);
    check("mid_rst_wdata", write_data, 32'd0);
    check("mid_rst_src", 32'(grant_src), 32'd0);
    check("mid_rst_busy9", 32'(q_busy2), 32'd0);
    tick();
    check("mid_rst_src_held", 32'(grant_src), 32'd0);
    rst_n = 1'b1;
    lsu_valid = 1'b1; lsu_addr = 5'd14; lsu_data = 32'h0000_000E;
    #1;
    check("post_rst_mdu_ready", 32'(mdu_ready), 32'd1);
    check("post_rst_lsu_ready", 32'(lsu_ready), 32'd0);
    tick();
    check("post_rst_src", 32'(grant_src), 32'(SRC_MDU));
    check("post_rst_waddr", 32'(write_addr), 32'd13);
    idle_inputs();
    tick();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
